// File: rtl/apu_pkg.sv
// rtl/apu_pkg.sv - shared APU widths, NRx2/NRx3 field positions and the noise divisor table
package apu_pkg;

    localparam int LFSR_W  = 15;
    localparam int VOL_W   = 4;
    localparam int TIMER_W = 20;

    localparam int NRX2_VOL_HI = 7;
    localparam int NRX2_VOL_LO = 4;
    localparam int NRX2_DIR    = 3;
    localparam int NRX2_PER_HI = 2;
    localparam int NRX2_PER_LO = 0;

    localparam int NRX3_SHIFT_HI = 7;
    localparam int NRX3_SHIFT_LO = 4;
    localparam int NRX3_WIDTH    = 3;
    localparam int NRX3_DIV_HI   = 2;
    localparam int NRX3_DIV_LO   = 0;

    localparam logic [7:0][6:0] DIVISOR_LUT = {
        7'd112, 7'd96, 7'd80, 7'd64, 7'd48, 7'd32, 7'd16, 7'd8
    };

    // Shift codes 14/15 overflow here; callers must not clock the timer for them.
    function automatic logic [TIMER_W-1:0] noise_period(input logic [7:0] nrx3);
        logic [TIMER_W-1:0] w_base;
        w_base = {{(TIMER_W-7){1'b0}}, DIVISOR_LUT[nrx3[NRX3_DIV_HI:NRX3_DIV_LO]]};
        return w_base << nrx3[NRX3_SHIFT_HI:NRX3_SHIFT_LO];
    endfunction

endpackage

// File: rtl/volume_envelope.sv
// rtl/volume_envelope.sv - NRx2 volume envelope shared by the square and noise channels
module volume_envelope
    import apu_pkg::*;
(
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_tick_64,
    input  logic             i_enable,
    input  logic             i_trigger,
    input  logic [7:0]       i_nrx2,
    output logic [VOL_W-1:0] o_volume
);

    localparam logic [VOL_W-1:0] VOL_ONE = 1;
    localparam logic [VOL_W-1:0] VOL_MAX = '1;

    logic [VOL_W-1:0] r_volume;
    logic [2:0]       r_env_timer;
    logic [2:0]       r_period;
    logic             r_dir;

    // Period and direction are latched so NRx2 writes only matter at the next trigger.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_volume    <= '0;
            r_env_timer <= '0;
            r_period    <= '0;
            r_dir       <= 1'b0;
        end else if (i_trigger) begin
            r_volume    <= i_nrx2[NRX2_VOL_HI:NRX2_VOL_LO];
            r_env_timer <= i_nrx2[NRX2_PER_HI:NRX2_PER_LO];
            r_period    <= i_nrx2[NRX2_PER_HI:NRX2_PER_LO];
            r_dir       <= i_nrx2[NRX2_DIR];
        end else if (i_tick_64 && i_enable && r_period != 3'd0) begin
            if (r_env_timer > 3'd1) begin
                r_env_timer <= r_env_timer - 3'd1;
            end else begin
                r_env_timer <= r_period;
                if (r_dir && r_volume != VOL_MAX) begin
                    r_volume <= r_volume + VOL_ONE;
                end else if (!r_dir && r_volume != '0) begin
                    r_volume <= r_volume - VOL_ONE;
                end
            end
        end
    end

    assign o_volume = r_volume;

endmodule

// File: rtl/noise_generator.sv
// rtl/noise_generator.sv - channel 4 noise source: LFSR, NR43 rate timer, trigger and DAC gating
module noise_generator
    import apu_pkg::*;
#(
    parameter logic [LFSR_W-1:0] LFSR_SEED = 15'h7FFF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick_64,
    input  logic [7:0] NR42,
    input  logic [7:0] NR43,
    input  logic [7:0] NR44,
    output logic [3:0] sample,
    output logic       active
);

    localparam logic [TIMER_W-1:0] TIMER_ONE = 1;

    logic [LFSR_W-1:0]  r_lfsr;
    logic [TIMER_W-1:0] r_timer;
    logic               r_trig_prev;
    logic               r_active;

    logic               w_trigger;
    logic               w_dac_on;
    logic               w_clocked;
    logic               w_x;
    logic [TIMER_W-1:0] w_period;
    logic [LFSR_W-1:0]  w_lfsr_next;
    logic [VOL_W-1:0]   w_volume;
    logic               w_nr44_unused;

    assign w_nr44_unused = ^NR44[6:0];

    assign w_trigger = NR44[7] & ~r_trig_prev;
    assign w_dac_on  = |NR42[NRX2_VOL_HI:NRX2_DIR];
    assign w_clocked = NR43[NRX3_SHIFT_HI:NRX3_SHIFT_LO] < 4'd14;
    assign w_period  = noise_period(NR43);
    assign w_x       = r_lfsr[0] ^ r_lfsr[1];

    always_comb begin
        w_lfsr_next = {w_x, r_lfsr[LFSR_W-1:1]};
        if (NR43[NRX3_WIDTH]) begin
            w_lfsr_next[6] = w_x;
        end
    end

    // Trigger outranks timer expiry; the timer reload samples NR43 live.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_trig_prev <= 1'b0;
            r_lfsr      <= LFSR_SEED;
            r_timer     <= '0;
            r_active    <= 1'b0;
        end else begin
            r_trig_prev <= NR44[7];
            if (!w_dac_on) begin
                r_active <= 1'b0;
            end else if (w_trigger) begin
                r_active <= 1'b1;
            end
            if (w_trigger) begin
                r_lfsr  <= LFSR_SEED;
                r_timer <= w_period;
            end else if (r_active && w_clocked) begin
                if (r_timer == TIMER_ONE) begin
                    r_lfsr  <= w_lfsr_next;
                    r_timer <= w_period;
                end else begin
                    r_timer <= r_timer - TIMER_ONE;
                end
            end
        end
    end

    volume_envelope u_envelope (
        .i_clock   (clock),
        .i_reset   (reset),
        .i_tick_64 (tick_64),
        .i_enable  (r_active),
        .i_trigger (w_trigger),
        .i_nrx2    (NR42),
        .o_volume  (w_volume)
    );

    assign active = r_active;
    assign sample = (r_active && !r_lfsr[0]) ? w_volume : 4'd0;

endmodule

// File: tb/tb_noise_generator.sv
// tb/tb_noise_generator.sv - scoreboard bench for noise_generator with hand-computed vectors
module tb_noise_generator;

    logic       clock = 1'b0;
    logic       reset;
    logic       tick_64;
    logic [7:0] NR42;
    logic [7:0] NR43;
    logic [7:0] NR44;
    logic [3:0] sample;
    logic       active;

    noise_generator #(.LFSR_SEED(15'h7FFF)) dut (
        .clock   (clock),
        .reset   (reset),
        .tick_64 (tick_64),
        .NR42    (NR42),
        .NR43    (NR43),
        .NR44    (NR44),
        .sample  (sample),
        .active  (active)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    localparam int K_SAMPLE = 0;
    localparam int K_ACTIVE = 1;
    localparam int K_LFSR   = 2;
    localparam int K_VOLUME = 3;

    typedef struct {
        int    cyc;
        int    kind;
        int    value;
        string name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   T;

    task automatic expect_at(input int at, input int kind, input int value, input string name);
        exp_t e;
        e.cyc   = at;
        e.kind  = kind;
        e.value = value;
        e.name  = name;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].cyc > at) begin
                exp_q.insert(i, e);
                return;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    task automatic pulse_trigger();
        NR44 = 8'h80;
        @(negedge clock);
        NR44 = 8'h00;
    endtask

    task automatic tick_pulse();
        tick_64 = 1'b1;
        @(negedge clock);
        tick_64 = 1'b0;
        @(negedge clock);
    endtask

    // Scoreboard monitor: entries come due by cycle stamp, DUT sampled on the falling edge.
    always @(negedge clock) begin
        exp_t e;
        int   act;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            case (e.kind)
                K_SAMPLE: act = int'(sample);
                K_ACTIVE: act = int'(active);
                K_LFSR:   act = int'(dut.r_lfsr);
                default:  act = int'(dut.u_envelope.r_volume);
            endcase
            n_checks++;
            if (act != e.value) begin
                n_fail++;
                $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", e.name, cyc, act, e.value);
            end
        end
    end

    initial begin
        int guard;
        reset   = 1'b1;
        tick_64 = 1'b0;
        NR42    = 8'hF3;
        NR43    = 8'h5A;
        NR44    = 8'h80;
        expect_at(2, K_SAMPLE, 0, "reset_sample");
        expect_at(2, K_ACTIVE, 0, "reset_active");
        expect_at(2, K_LFSR, 'h7FFF, "reset_lfsr");
        idle(2);
        reset = 1'b0;
        NR44  = 8'h00;
        NR42  = 8'hF0;
        NR43  = 8'h00;
        idle(1);

        T = cyc + 1;
        expect_at(T, K_ACTIVE, 1, "trig_active");
        expect_at(T, K_LFSR, 'h7FFF, "trig_seed");
        expect_at(T + 8, K_LFSR, 'h3FFF, "first_step");
        expect_at(T + 112, K_LFSR, 'h0001, "lfsr_14_steps");
        expect_at(T + 119, K_SAMPLE, 0, "sample_pre");
        expect_at(T + 120, K_SAMPLE, 15, "first_sample");
        expect_at(T + 120, K_LFSR, 'h4000, "lfsr_15_steps");
        pulse_trigger();
        wait_until(T + 121);

        NR43 = 8'h08;
        T = cyc + 1;
        expect_at(T + 7, K_LFSR, 'h7FFF, "width_hold");
        expect_at(T + 8, K_LFSR, 'h3FBF, "width_step1");
        expect_at(T + 16, K_LFSR, 'h1F9F, "width_step2");
        pulse_trigger();
        wait_until(T + 17);

        NR43 = 8'h11;
        T = cyc + 1;
        expect_at(T + 31, K_LFSR, 'h7FFF, "period32_hold");
        expect_at(T + 32, K_LFSR, 'h3FFF, "period32_step");
        pulse_trigger();
        wait_until(T + 33);

        NR43 = 8'hE0;
        T = cyc + 1;
        expect_at(T + 5000, K_LFSR, 'h7FFF, "noclk_lfsr_mid");
        expect_at(T + 20000, K_LFSR, 'h7FFF, "noclk_lfsr_end");
        expect_at(T + 20000, K_SAMPLE, 0, "noclk_sample");
        expect_at(T + 20000, K_ACTIVE, 1, "noclk_active");
        pulse_trigger();
        wait_until(T + 20001);

        NR42 = 8'hF1;
        T = cyc + 1;
        expect_at(T, K_VOLUME, 15, "env_down_load");
        pulse_trigger();
        for (int k = 1; k <= 16; k++) begin
            expect_at(cyc + 1, K_VOLUME, (k > 15) ? 0 : 15 - k, "env_down");
            tick_pulse();
        end
        expect_at(cyc + 1, K_ACTIVE, 1, "env_down_active");
        idle(1);

        NR42 = 8'h09;
        T = cyc + 1;
        expect_at(T, K_VOLUME, 0, "env_up_load");
        pulse_trigger();
        for (int k = 1; k <= 16; k++) begin
            expect_at(cyc + 1, K_VOLUME, (k > 15) ? 15 : k, "env_up");
            tick_pulse();
        end
        idle(1);

        NR42 = 8'hA2;
        T = cyc + 1;
        expect_at(T, K_VOLUME, 10, "env_trig_wins");
        tick_64 = 1'b1;
        pulse_trigger();
        tick_64 = 1'b0;
        expect_at(cyc + 1, K_VOLUME, 10, "env_n2_tick1");
        tick_pulse();
        expect_at(cyc + 1, K_VOLUME, 9, "env_n2_tick2");
        tick_pulse();
        expect_at(cyc + 1, K_VOLUME, 9, "env_n2_tick3");
        tick_pulse();
        expect_at(cyc + 1, K_VOLUME, 8, "env_n2_tick4");
        tick_pulse();

        NR42 = 8'h00;
        expect_at(cyc + 1, K_ACTIVE, 0, "dac_off_drop");
        idle(1);
        T = cyc + 1;
        expect_at(T, K_ACTIVE, 0, "dac_off_trigger");
        expect_at(T, K_SAMPLE, 0, "dac_off_sample");
        pulse_trigger();
        idle(2);

        NR42 = 8'hF0;
        NR43 = 8'h00;
        T = cyc + 1;
        expect_at(T, K_ACTIVE, 1, "held_active");
        expect_at(T, K_LFSR, 'h7FFF, "held_seed");
        expect_at(T + 8, K_LFSR, 'h3FFF, "held_step1");
        expect_at(T + 16, K_LFSR, 'h1FFF, "held_step2");
        expect_at(T + 24, K_LFSR, 'h0FFF, "held_step3");
        NR44 = 8'h80;
        idle(20);
        NR44 = 8'h00;
        wait_until(T + 25);

        reset = 1'b1;
        NR44  = 8'h80;
        expect_at(cyc + 1, K_ACTIVE, 0, "midrst_active");
        expect_at(cyc + 1, K_LFSR, 'h7FFF, "midrst_lfsr");
        expect_at(cyc + 1, K_SAMPLE, 0, "midrst_sample");
        idle(1);
        reset = 1'b0;
        NR44  = 8'h00;
        expect_at(cyc + 2, K_ACTIVE, 0, "post_rst_active");
        idle(3);

        guard = 0;
        while (exp_q.size() > 0 && guard < 1000) begin
            @(negedge clock);
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
